// File: rtl/perceptron_trainer.sv
// Online trainer for an 8x8 single-layer perceptron, one neuron evaluated and updated per cycle.
// Define PERCEPTRON_TRAINER_SAT_EN for saturating weight/bias updates; otherwise updates wrap modulo 256.
module perceptron_trainer #(
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [7:0]          sample_in,
    input  logic [7:0]          target,
    output logic                done,
    output logic [7:0]          upd_mask,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                wr_en,
    input  logic [6:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [6:0]          rd_addr,
    output logic [7:0]          rd_data
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t            state;
    logic signed [7:0] wmem [8][9];
    logic [7:0]        sample_lat;
    logic [7:0]        target_lat;
    logic [7:0]        mask_acc;
    logic [7:0]        mask_next;
    logic [2:0]        nidx;
    logic signed [11:0] nsum;
    logic              y;
    logic              mismatch;
    logic              accept;
    logic              wr_ok;

    function automatic logic signed [11:0] sext(input logic signed [7:0] v);
        return {{4{v[7]}}, v};
    endfunction

    function automatic logic signed [7:0] step(input logic signed [7:0] v, input logic up);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        if (up)
            return (v == 8'sd127) ? v : v + 8'sd1;
        else
            return (v == -8'sd128) ? v : v - 8'sd1;
`else
        return up ? v + 8'sd1 : v - 8'sd1;
`endif
    endfunction

    assign accept = sample_valid && sample_ready;
    assign wr_ok  = wr_en && (state == IDLE) && !accept && (wr_addr[3:0] <= 4'd8);

    // 12 bits hold bias plus eight weights of magnitude <= 128 without overflow.
    always_comb begin
        nsum = sext(wmem[nidx][8]);
        for (int i = 0; i < 8; i++) begin
            if (sample_lat[i])
                nsum = nsum + sext(wmem[nidx][i]);
        end
        y         = (nsum > 12'sd0);
        mismatch  = (y != target_lat[nidx]);
        mask_next = mask_acc;
        mask_next[nidx] = mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
            done         <= 1'b0;
            nidx         <= 3'd0;
            sample_lat   <= 8'd0;
            target_lat   <= 8'd0;
            mask_acc     <= 8'd0;
            upd_mask     <= 8'd0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        sample_lat   <= sample_in;
                        target_lat   <= target;
                        nidx         <= 3'd0;
                        sample_ready <= 1'b0;
                        state        <= EVAL;
                    end
                end
                EVAL: begin
                    mask_acc <= mask_next;
                    if (mismatch && (err_count != '1))
                        err_count <= err_count + ERRCNT_W'(1);
                    if (nidx == 3'd7) begin
                        upd_mask <= mask_next;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        nidx <= nidx + 3'd1;
                    end
                end
                DONE: begin
                    done         <= 1'b0;
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    done         <= 1'b0;
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Training updates and preload writes are mutually exclusive by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 8; n++)
                for (int i = 0; i < 9; i++)
                    wmem[n][i] <= 8'sd0;
        end else if (state == EVAL) begin
            if (mismatch) begin
                for (int i = 0; i < 8; i++) begin
                    if (sample_lat[i])
                        wmem[nidx][i] <= step(wmem[nidx][i], target_lat[nidx]);
                end
                wmem[nidx][8] <= step(wmem[nidx][8], target_lat[nidx]);
            end
        end else if (wr_ok) begin
            wmem[wr_addr[6:4]][wr_addr[3:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= 8'd0;
        else if (rd_addr[3:0] <= 4'd8)
            rd_data <= wmem[rd_addr[6:4]][rd_addr[3:0]];
        else
            rd_data <= 8'd0;
    end

endmodule
